// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multi-cycle RV32I control unit:
// opcodes, ALU/memory codes, PC sources, FSM states and decode bundle.
package multicycle_control_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_SLL    = 5'd2;
  localparam logic [4:0] ALU_SLT    = 5'd3;
  localparam logic [4:0] ALU_SLTU   = 5'd4;
  localparam logic [4:0] ALU_XOR    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_OR     = 5'd8;
  localparam logic [4:0] ALU_AND    = 5'd9;
  localparam logic [4:0] ALU_LUI    = 5'd10;
  // M codes follow func3 order so decode is ALU_MUL + func3
  localparam logic [4:0] ALU_MUL    = 5'd11;
  localparam logic [4:0] ALU_MULH   = 5'd12;
  localparam logic [4:0] ALU_MULHSU = 5'd13;
  localparam logic [4:0] ALU_MULHU  = 5'd14;
  localparam logic [4:0] ALU_DIV    = 5'd15;
  localparam logic [4:0] ALU_DIVU   = 5'd16;
  localparam logic [4:0] ALU_REM    = 5'd17;
  localparam logic [4:0] ALU_REMU   = 5'd18;

  localparam logic [2:0] MEMREAD_NONE = 3'd0;
  localparam logic [2:0] MEMREAD_LB   = 3'd1;
  localparam logic [2:0] MEMREAD_LH   = 3'd2;
  localparam logic [2:0] MEMREAD_LW   = 3'd3;
  localparam logic [2:0] MEMREAD_LBU  = 3'd4;
  localparam logic [2:0] MEMREAD_LHU  = 3'd5;

  localparam logic [1:0] MEMWRITE_NONE = 2'd0;
  localparam logic [1:0] MEMWRITE_SB   = 2'd1;
  localparam logic [1:0] MEMWRITE_SH   = 2'd2;
  localparam logic [1:0] MEMWRITE_SW   = 2'd3;

  localparam logic [1:0] PC_SRC_PC4 = 2'b00;
  localparam logic [1:0] PC_SRC_IMM = 2'b01;
  localparam logic [1:0] PC_SRC_REG = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    K_ALU, K_LOAD, K_STORE, K_BRANCH, K_JAL, K_JALR
  } kind_t;

  typedef struct packed {
    kind_t      kind;
    logic [4:0] aluop;
    logic       src1;
    logic       src2;
    logic [2:0] memread;
    logic [1:0] memwrite;
    logic       illegal;
  } ctrl_t;

  function automatic logic [4:0] alu_base(
    input logic [2:0] f3,
    input logic       alt
  );
    logic [4:0] r;
    r = ALU_ADD;
    case (f3)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational opcode/func decode into control fields plus
// an illegal flag; registered by the sequencer in DECODE.
module insn_decode
  import multicycle_control_pkg::*;
#(
  parameter bit SUPPORT_M = 1'b0
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_bits;

  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign unused_bits = ^{instr[24:15], instr[11:7]};

  always_comb begin
    ctrl.kind     = K_ALU;
    ctrl.aluop    = ALU_ADD;
    ctrl.src1     = 1'b0;
    ctrl.src2     = 1'b0;
    ctrl.memread  = MEMREAD_NONE;
    ctrl.memwrite = MEMWRITE_NONE;
    ctrl.illegal  = 1'b0;
    unique case (1'b1)
      op == OPC_LUI: begin
        ctrl.aluop = ALU_LUI;
        ctrl.src2  = 1'b1;
      end
      op == OPC_AUIPC: begin
        ctrl.src1 = 1'b1;
        ctrl.src2 = 1'b1;
      end
      op == OPC_JAL: begin
        ctrl.kind = K_JAL;
        ctrl.src1 = 1'b1;
        ctrl.src2 = 1'b1;
      end
      op == OPC_JALR: begin
        ctrl.kind    = K_JALR;
        ctrl.src2    = 1'b1;
        ctrl.illegal = (f3 != 3'b000);
      end
      op == OPC_BRANCH: begin
        ctrl.kind = K_BRANCH;
        case (f3)
          3'b000, 3'b001: ctrl.aluop = ALU_SUB;
          3'b100, 3'b101: ctrl.aluop = ALU_SLT;
          3'b110, 3'b111: ctrl.aluop = ALU_SLTU;
          default:        ctrl.illegal = 1'b1;
        endcase
      end
      op == OPC_LOAD: begin
        ctrl.kind = K_LOAD;
        ctrl.src2 = 1'b1;
        case (f3)
          3'b000:  ctrl.memread = MEMREAD_LB;
          3'b001:  ctrl.memread = MEMREAD_LH;
          3'b010:  ctrl.memread = MEMREAD_LW;
          3'b100:  ctrl.memread = MEMREAD_LBU;
          3'b101:  ctrl.memread = MEMREAD_LHU;
          default: ctrl.illegal = 1'b1;
        endcase
      end
      op == OPC_STORE: begin
        ctrl.kind = K_STORE;
        ctrl.src2 = 1'b1;
        case (f3)
          3'b000:  ctrl.memwrite = MEMWRITE_SB;
          3'b001:  ctrl.memwrite = MEMWRITE_SH;
          3'b010:  ctrl.memwrite = MEMWRITE_SW;
          default: ctrl.illegal = 1'b1;
        endcase
      end
      op == OPC_OPIMM: begin
        ctrl.src2  = 1'b1;
        ctrl.aluop = alu_base(f3, (f3 == 3'b101) && f7[5]);
      end
      op == OPC_OP: begin
        if (f7 == 7'b0000000)
          ctrl.aluop = alu_base(f3, 1'b0);
        else if (f7 == 7'b0100000 &&
                 (f3 == 3'b000 || f3 == 3'b101))
          ctrl.aluop = alu_base(f3, 1'b1);
        else if (SUPPORT_M && f7 == 7'b0000001)
          ctrl.aluop = ALU_MUL + {2'b00, f3};
        else
          ctrl.illegal = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle RV32I
// core with variable-latency memory handshakes and optional timeout.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int ALUOP_W     = 5,
  parameter bit SUPPORT_M   = 1'b0,
  parameter int MEM_TIMEOUT = 0,
  parameter int TO_W        = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        instr,
  input  logic               branch_taken,
  output logic               imem_req,
  input  logic               imem_ready,
  output logic               dmem_req,
  input  logic               dmem_ready,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               Alusrc1,
  output logic               Alusrc2,
  output logic [ALUOP_W-1:0] Aluop,
  output logic [2:0]         MemRead,
  output logic [1:0]         MemWrite,
  output logic               MemtoReg,
  output logic               Add4,
  output logic               RegWrite,
  output logic               illegal,
  output logic               bus_err,
  output logic [2:0]         state_o
);

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT - 1);

  state_t          state, state_n;
  ctrl_t           dec, q;
  logic [TO_W-1:0] cnt;
  logic [4:0]      aluop_i;
  logic            waiting;
  logic            to_hit;
  logic            unused_q;

  insn_decode #(.SUPPORT_M(SUPPORT_M)) u_dec (
    .instr (instr),
    .ctrl  (dec)
  );

  assign waiting = (state == S_FETCH && !imem_ready) ||
                   (state == S_MEM && !dmem_ready);
  // limit is hit in the wait cycle that would make the count MEM_TIMEOUT
  assign to_hit   = (MEM_TIMEOUT != 0) && (cnt == TO_LIM);
  assign state_o  = state;
  assign Aluop    = ALUOP_W'(aluop_i);
  assign unused_q = q.illegal;

  always_comb begin
    state_n  = state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src   = PC_SRC_PC4;
    Alusrc1  = 1'b0;
    Alusrc2  = 1'b0;
    aluop_i  = ALU_ADD;
    MemRead  = MEMREAD_NONE;
    MemWrite = MEMWRITE_NONE;
    MemtoReg = 1'b0;
    Add4     = 1'b0;
    RegWrite = 1'b0;
    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      Alusrc1 = q.src1;
      Alusrc2 = q.src2;
      aluop_i = q.aluop;
    end
    unique case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write = 1'b1;
          state_n  = S_DECODE;
        end else if (to_hit) begin
          state_n = S_TRAP;
        end
      end
      S_DECODE: state_n = dec.illegal ? S_TRAP : S_EXEC;
      S_EXEC: begin
        unique case (q.kind)
          K_BRANCH: begin
            pc_write = branch_taken;
            pc_src   = PC_SRC_IMM;
            state_n  = S_FETCH;
          end
          K_LOAD, K_STORE: state_n = S_MEM;
          default:         state_n = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        MemRead  = q.memread;
        MemWrite = q.memwrite;
        if (dmem_ready) begin
          if (q.kind == K_LOAD) begin
            state_n = S_WB;
          end else begin
            pc_write = 1'b1;
            state_n  = S_FETCH;
          end
        end else if (to_hit) begin
          state_n = S_TRAP;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        pc_write = 1'b1;
        state_n  = S_FETCH;
        unique case (q.kind)
          K_JAL: begin
            pc_src = PC_SRC_IMM;
            Add4   = 1'b1;
          end
          K_JALR: begin
            pc_src = PC_SRC_REG;
            Add4   = 1'b1;
          end
          K_LOAD:  MemtoReg = 1'b1;
          default: pc_src = PC_SRC_PC4;
        endcase
      end
      S_TRAP:  state_n = S_TRAP;
      default: state_n = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      q       <= '0;
      cnt     <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_DECODE) begin
        q <= dec;
        if (dec.illegal) illegal <= 1'b1;
      end
      if (state_n != state) cnt <= '0;
      else                  cnt <= cnt + TO_W'(waiting);
      if (waiting && to_hit) bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one instance with RV32M
// and a 4-cycle timeout, one with defaults for the illegal-M path.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        branch_taken = 1'b0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;

  logic       imem_req, dmem_req, ir_write, pc_write;
  logic [1:0] pc_src, MemWrite;
  logic       Alusrc1, Alusrc2, MemtoReg, Add4, RegWrite;
  logic [4:0] Aluop;
  logic [2:0] MemRead, state_o;
  logic       illegal, bus_err;

  logic       b_imem_req, b_dmem_req, b_ir_write, b_pc_write;
  logic [1:0] b_pc_src, b_MemWrite;
  logic       b_Alusrc1, b_Alusrc2, b_MemtoReg, b_Add4, b_RegWrite;
  logic [4:0] b_Aluop;
  logic [2:0] b_MemRead, b_state_o;
  logic       b_illegal, b_bus_err;

  int npass = 0;
  int ntot = 0;

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_LW  = 32'h0040A283;
  localparam logic [31:0] I_BEQ = 32'h00208463;
  localparam logic [31:0] I_MUL = 32'h022081B3;
  localparam logic [31:0] I_SW  = 32'h00512423;

  multicycle_control #(
    .ALUOP_W(5), .SUPPORT_M(1'b1), .MEM_TIMEOUT(4), .TO_W(8)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .branch_taken(branch_taken),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .Alusrc1(Alusrc1), .Alusrc2(Alusrc2), .Aluop(Aluop),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .Add4(Add4), .RegWrite(RegWrite),
    .illegal(illegal), .bus_err(bus_err), .state_o(state_o)
  );

  multicycle_control dut_b (
    .clk(clk), .rst_n(rst_n), .instr(instr),
    .branch_taken(branch_taken),
    .imem_req(b_imem_req), .imem_ready(imem_ready),
    .dmem_req(b_dmem_req), .dmem_ready(dmem_ready),
    .ir_write(b_ir_write), .pc_write(b_pc_write),
    .pc_src(b_pc_src),
    .Alusrc1(b_Alusrc1), .Alusrc2(b_Alusrc2), .Aluop(b_Aluop),
    .MemRead(b_MemRead), .MemWrite(b_MemWrite),
    .MemtoReg(b_MemtoReg), .Add4(b_Add4), .RegWrite(b_RegWrite),
    .illegal(b_illegal), .bus_err(b_bus_err),
    .state_o(b_state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    ntot++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      npass++;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    branch_taken = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic fetch(input logic [31:0] ins);
    instr = ins;
    imem_ready = 1'b1;
    #1;
    check("fetch_state", state_o, 0);
    check("fetch_irw", ir_write, 1);
    tick();
    imem_ready = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    check("rst_state", state_o, 0);
    check("rst_imem_req", imem_req, 1);
    check("rst_irw", ir_write, 0);
    check("rst_pcw", pc_write, 0);
    check("rst_regw", RegWrite, 0);
    check("rst_mem", {MemRead, MemWrite, dmem_req}, 0);
    check("rst_aluop", Aluop, 0);
    check("rst_pcsrc", pc_src, 0);
    check("rst_flags", {illegal, bus_err}, 0);

    // add: F D E W
    fetch(I_ADD);
    check("add_dec", state_o, 1);
    check("add_dec_rw", RegWrite, 0);
    tick();
    check("add_exec", state_o, 2);
    check("add_aluop", Aluop, ALU_ADD);
    check("add_src2", Alusrc2, 0);
    check("add_exec_strb", {RegWrite, pc_write}, 0);
    tick();
    check("add_wb", state_o, 4);
    check("add_wb_strb", {RegWrite, pc_write}, 2'b11);
    check("add_wb_pcsrc", pc_src, PC_SRC_PC4);
    check("add_wb_misc", {Add4, MemtoReg}, 0);
    tick();
    check("add_done", state_o, 0);

    // lw with ready on the 4th MEM cycle (at the timeout limit)
    fetch(I_LW);
    tick();
    check("lw_exec", state_o, 2);
    check("lw_src2", Alusrc2, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      dmem_ready = (i == 3);
      #1;
      check("lw_mem", state_o, 3);
      check("lw_dreq", dmem_req, 1);
      check("lw_memread", MemRead, MEMREAD_LW);
      tick();
    end
    dmem_ready = 1'b0;
    #1;
    check("lw_wb", state_o, 4);
    check("lw_wb_m2r", MemtoReg, 1);
    check("lw_wb_rw", RegWrite, 1);
    check("lw_wb_mr", MemRead, 0);
    check("lw_no_buserr", bus_err, 0);
    tick();
    check("lw_done", state_o, 0);

    // beq taken then not taken
    for (int t = 1; t >= 0; t--) begin
      fetch(I_BEQ);
      tick();
      branch_taken = t[0];
      #1;
      check("beq_exec", state_o, 2);
      check("beq_pcw", pc_write, t[0]);
      check("beq_pcsrc", pc_src, PC_SRC_IMM);
      check("beq_rw", RegWrite, 0);
      tick();
      branch_taken = 1'b0;
      check("beq_done", state_o, 0);
      check("beq_rw2", RegWrite, 0);
    end

    // mul: legal on dut_a, trap on dut_b
    do_reset();
    fetch(I_MUL);
    check("mul_b_dec", b_state_o, 1);
    tick();
    check("mul_aluop", Aluop, ALU_MUL);
    check("mul_b_trap", b_state_o, 5);
    check("mul_b_ill", b_illegal, 1);
    check("mul_a_ill", illegal, 0);
    tick();
    check("mul_wb_rw", RegWrite, 1);
    check("mul_b_strb", {b_RegWrite, b_pc_write, b_imem_req}, 0);
    imem_ready = 1'b1;
    #1;
    check("mul_b_hold", {b_state_o, b_ir_write, b_imem_req},
          {3'd5, 2'b00});
    tick();
    imem_ready = 1'b0;
    check("mul_b_sticky", b_illegal, 1);

    // imem timeout after 4 waiting cycles
    do_reset();
    for (int i = 0; i < 4; i++) begin
      check("to_wait", {state_o, imem_req}, {3'd0, 1'b1});
      tick();
    end
    check("to_trap", state_o, 5);
    check("to_buserr", bus_err, 1);
    check("to_req_drop", imem_req, 0);
    check("to_b_none", b_bus_err, 0);
    do_reset();
    check("to_rst", {state_o, bus_err, imem_req}, {3'd0, 2'b01});

    // ready exactly at the limit wins
    tick();
    tick();
    tick();
    fetch(I_SW);
    check("lim_dec", state_o, 1);
    check("lim_buserr", bus_err, 0);
    tick();
    tick();
    check("sw_mem", state_o, 3);
    check("sw_mem_io", {dmem_req, MemWrite, MemRead},
          {1'b1, MEMWRITE_SW, MEMREAD_NONE});
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("swr_state", state_o, 0);
    check("swr_mw", MemWrite, 0);
    check("swr_dreq", dmem_req, 0);
    dmem_ready = 1'b1;
    #1;
    check("late_ready_irw", ir_write, 0);
    tick();
    check("late_ready_st", {state_o, dmem_req}, 0);
    dmem_ready = 1'b0;

    // normal sw completion
    fetch(I_SW);
    tick();
    tick();
    dmem_ready = 1'b1;
    #1;
    check("sw_pcw", {pc_write, pc_src}, {1'b1, PC_SRC_PC4});
    check("sw_mw", MemWrite, MEMWRITE_SW);
    tick();
    dmem_ready = 1'b0;
    check("sw_done", {state_o, RegWrite}, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
